fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Front-end controller that sequences the 6502 decoder.
- Fetches the opcode at PC, then fetches operand bytes according to the addressing-mode field.
- Resolves the effective address, including indexed and indirect pointer reads.
- Presents the instruction to the decoder with instruction_ready and holds it until instruction_done, then advances PC.
- Sole master of the memory read port during fetch; the decoder's own memory writes occur only while this block is in WAIT_DONE.

Parameters:
- ADDR_WIDTH, 16, address/PC width.
- REG_WIDTH, 8, data/opcode width.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- run  in  1  when high, IDLE starts a new fetch.
- pc_load  in  1  load PC from pc_load_val; honoured in IDLE or WAIT_DONE only.
- pc_load_val  in  ADDR_WIDTH  new PC value.
- x_in  in  REG_WIDTH  current X register.
- y_in  in  REG_WIDTH  current Y register.
- mem_addr  out  ADDR_WIDTH  read address.
- mem_rd  out  1  read request, held until mem_valid.
- mem_rdata  in  REG_WIDTH  read data, valid with mem_valid.
- mem_valid  in  1  read completion strobe.
- instruction  out  REG_WIDTH  latched opcode.
- operand  out  REG_WIDTH  immediate byte (imm mode); 0 otherwise.
- eff_addr  out  ADDR_WIDTH  resolved effective address; 0 for imm/implied.
- instruction_ready  out  1  instruction valid to decoder.
- instruction_done  in  1  decoder completion.
- pc  out  ADDR_WIDTH  current PC.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (reset_n low at posedge clk): state=IDLE, pc=RESET_PC, all other outputs 0. Reset wins over every other event, including mid-fetch; an outstanding mem_valid after reset is ignored.
- Mode decode uses opcode cc=[1:0], bbb=[4:2]:
  - cc=01: 000 (zp,X); 001 zp; 010 imm; 011 abs; 100 (zp),Y; 101 zp,X; 110 abs,Y; 111 abs,X.
  - cc=10 / cc=00: 000 imm; 001 zp; 011 abs; 101 zp,X; 111 abs,X; all other bbb implied.
  - cc=11: implied.
- States:
  - IDLE: if run, go to FETCH_OP with mem_addr=pc, mem_rd=1.
  - FETCH_OP: on mem_valid, latch instruction, pc+=1. Go to ISSUE if implied, else FETCH_LO.
  - FETCH_LO: read at pc; on mem_valid, pc+=1, latch lo.
    - imm: operand=lo, go to ISSUE.
    - zp: eff={8'h00,lo}, go to ISSUE.
    - zp,X: eff={8'h00,(lo+x_in) mod 256}, go to ISSUE.
    - abs, abs,X, abs,Y: go to FETCH_HI.
    - (zp,X): ptr=(lo+x_in) mod 256, go to PTR_LO.
    - (zp),Y: ptr=lo, go to PTR_LO.
  - FETCH_HI: read at pc; on mem_valid, pc+=1. eff={hi,lo}+0/x_in/y_in, modulo 2^16 (0xFFFF+1 wraps to 0x0000). Go to ISSUE.
  - PTR_LO: read {8'h00,ptr}. Go to PTR_HI.
  - PTR_HI: read {8'h00,(ptr+1) mod 256}; the pointer wraps inside page zero (ptr=FF reads FF then 00). eff={hi,lo}, plus y_in for (zp),Y, modulo 2^16. Go to ISSUE.
  - ISSUE: instruction_ready=1 (registered, one cycle after the final fetch). Go to WAIT_DONE.
  - WAIT_DONE: instruction_ready stays high and instruction/operand/eff_addr are stable. On instruction_done: ready=0. If pc_load in the same cycle, pc=pc_load_val. Go to IDLE.
- mem_rd is high only in fetch states. mem_addr changes only on a state transition. mem_valid outside a fetch state is ignored.
- pc_load asserted in a fetch state is ignored.
- instruction_done asserted outside WAIT_DONE is ignored.
- Minimum latency, zero-wait memory: implied 3 cycles run→ready; abs 5; indirect 7.

Optional Feature:
- FETCH_PAGE_CROSS_EN
- Defined:
  - For abs,X, abs,Y and (zp),Y, when the index add carries into the high byte, insert one PENALTY state before ISSUE.
  - Assert output page_cross (1 bit) with instruction_ready; it clears with ready.
- Undefined:
  - No PENALTY state; page_cross is tied to 0.

Test Plan:
- Reset with RESET_PC=16'h0200, then run=1; memory [0200]=A9 (LDA imm), [0201]=42 -> instruction=A9, operand=42, eff_addr=0, ready held until done, pc=0202.
- [0300]=B5 (zp,X), [0301]=F0, x_in=20 -> eff_addr=0010 (zero-page wrap); 0300 reached via pc_load in IDLE.
- [0400]=7D (abs,X), [0401]=F0, [0402]=12, x_in=20 -> eff_addr=1310, pc=0403; with FETCH_PAGE_CROSS_EN, one extra cycle and page_cross=1.
- [0500]=B1 ((zp),Y), [0501]=FF, [00FF]=34, [0000]=12, y_in=05 -> pointer reads at 00FF then 0000, eff_addr=1239.
- mem_valid delayed 3 cycles per read -> mem_rd and mem_addr held stable; reset_n low mid-FETCH_HI -> IDLE, pc=RESET_PC, ready=0, a late mem_valid is ignored.
- instruction_done pulsed in FETCH_OP -> ignored; pc_load in WAIT_DONE coincident with instruction_done -> pc=pc_load_val.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Memory read port between the fetch sequencer (master) and instruction memory (slave).
interface fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH  = 8
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic [REG_WIDTH-1:0]  mem_rdata;
  logic                  mem_valid;

  modport master (output mem_addr, mem_rd, input mem_rdata, mem_valid);
  modport slave  (input mem_addr, mem_rd, output mem_rdata, mem_valid);
endinterface

// File: rtl/fetch_sequencer.sv
// 6502 front end: fetches opcode and operands, resolves the effective address, hands off to the decoder.
// Define FETCH_PAGE_CROSS_EN to add a PENALTY cycle and page_cross flag on indexed page crossings.
module fetch_sequencer #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    REG_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_val,
  input  logic [REG_WIDTH-1:0]  x_in,
  input  logic [REG_WIDTH-1:0]  y_in,
  fetch_sequencer_if.master     mem,
  output logic [REG_WIDTH-1:0]  instruction,
  output logic [REG_WIDTH-1:0]  operand,
  output logic [ADDR_WIDTH-1:0] eff_addr,
  output logic                  instruction_ready,
  input  logic                  instruction_done,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  page_cross
);

  typedef enum logic [3:0] {
    IDLE, FETCH_OP, FETCH_LO, FETCH_HI, PTR_LO, PTR_HI,
`ifdef FETCH_PAGE_CROSS_EN
    PENALTY,
`endif
    ISSUE, WAIT_DONE
  } state_t;

  typedef enum logic [3:0] {
    M_IMPL, M_IMM, M_ZP, M_ZPX, M_ABS, M_ABSX, M_ABSY, M_INDX, M_INDY
  } mode_t;

  function automatic mode_t decode_mode(input logic [4:0] op);
    mode_t m;
    m = M_IMPL;
    case (op[1:0])
      2'b01: case (op[4:2])
        3'd0: m = M_INDX;
        3'd1: m = M_ZP;
        3'd2: m = M_IMM;
        3'd3: m = M_ABS;
        3'd4: m = M_INDY;
        3'd5: m = M_ZPX;
        3'd6: m = M_ABSY;
        default: m = M_ABSX;
      endcase
      2'b00, 2'b10: case (op[4:2])
        3'd0: m = M_IMM;
        3'd1: m = M_ZP;
        3'd3: m = M_ABS;
        3'd5: m = M_ZPX;
        3'd7: m = M_ABSX;
        default: m = M_IMPL;
      endcase
      default: m = M_IMPL;
    endcase
    return m;
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, addr_q, addr_d, eff_q, eff_d;
  logic                  rd_q, rd_d, ready_q, ready_d;
  logic [REG_WIDTH-1:0]  instr_q, instr_d, operand_q, operand_d;
  logic [REG_WIDTH-1:0]  lo_q, lo_d, ptr_q, ptr_d;

  mode_t                 mode;
  logic [REG_WIDTH-1:0]  idx, zp_sum, ptr_inc, hi_sum;
  logic [REG_WIDTH:0]    lo_idx;
  logic [ADDR_WIDTH-1:0] pc_inc, indexed_addr;

  assign mode    = decode_mode(instr_q[4:0]);
  assign idx     = (mode == M_ABSX) ? x_in :
                   (mode == M_ABSY || mode == M_INDY) ? y_in : '0;
  assign zp_sum  = mem.mem_rdata + x_in;
  assign ptr_inc = ptr_q + REG_WIDTH'(1);
  assign pc_inc  = pc_q + ADDR_WIDTH'(1);
  // The carry out of the low-byte index add is both the high-byte increment and the page-cross flag.
  assign lo_idx       = {1'b0, lo_q} + {1'b0, idx};
  assign hi_sum       = mem.mem_rdata + {{(REG_WIDTH-1){1'b0}}, lo_idx[REG_WIDTH]};
  assign indexed_addr = {hi_sum, lo_idx[REG_WIDTH-1:0]};

`ifdef FETCH_PAGE_CROSS_EN
  logic cross_q, cross_d, page_cross_q, page_cross_d;
  assign page_cross = page_cross_q;
`else
  assign page_cross = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    instr_d   = instr_q;
    operand_d = operand_q;
    eff_d     = eff_q;
    lo_d      = lo_q;
    ptr_d     = ptr_q;
    ready_d   = ready_q;
`ifdef FETCH_PAGE_CROSS_EN
    cross_d      = cross_q;
    page_cross_d = page_cross_q;
`endif
    case (state_q)
      IDLE: begin
        if (pc_load) pc_d = pc_load_val;
        if (run) begin
          state_d = FETCH_OP;
          addr_d  = pc_d;
          rd_d    = 1'b1;
        end
      end
      FETCH_OP: if (mem.mem_valid) begin
        instr_d   = mem.mem_rdata;
        operand_d = '0;
        eff_d     = '0;
        pc_d      = pc_inc;
`ifdef FETCH_PAGE_CROSS_EN
        cross_d   = 1'b0;
`endif
        if (decode_mode(mem.mem_rdata[4:0]) == M_IMPL) begin
          state_d = ISSUE;
          rd_d    = 1'b0;
        end else begin
          state_d = FETCH_LO;
          addr_d  = pc_inc;
        end
      end
      FETCH_LO: if (mem.mem_valid) begin
        pc_d = pc_inc;
        lo_d = mem.mem_rdata;
        case (mode)
          M_IMM: begin operand_d = mem.mem_rdata; state_d = ISSUE; rd_d = 1'b0; end
          M_ZP:  begin eff_d = {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, mem.mem_rdata}; state_d = ISSUE; rd_d = 1'b0; end
          M_ZPX: begin eff_d = {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, zp_sum}; state_d = ISSUE; rd_d = 1'b0; end
          // Indirect modes drop mem_rd for one pointer-add cycle before reading page zero.
          M_INDX, M_INDY: begin
            ptr_d   = (mode == M_INDX) ? zp_sum : mem.mem_rdata;
            addr_d  = {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, ptr_d};
            rd_d    = 1'b0;
            state_d = PTR_LO;
          end
          default: begin addr_d = pc_inc; state_d = FETCH_HI; end
        endcase
      end
      FETCH_HI, PTR_HI: if (mem.mem_valid) begin
        if (state_q == FETCH_HI) pc_d = pc_inc;
        eff_d = indexed_addr;
        rd_d  = 1'b0;
`ifdef FETCH_PAGE_CROSS_EN
        cross_d = lo_idx[REG_WIDTH];
        state_d = lo_idx[REG_WIDTH] ? PENALTY : ISSUE;
`else
        state_d = ISSUE;
`endif
      end
      PTR_LO: begin
        if (!rd_q) begin
          rd_d = 1'b1;
        end else if (mem.mem_valid) begin
          lo_d    = mem.mem_rdata;
          addr_d  = {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, ptr_inc};
          state_d = PTR_HI;
        end
      end
`ifdef FETCH_PAGE_CROSS_EN
      PENALTY: state_d = ISSUE;
`endif
      ISSUE: begin
        ready_d = 1'b1;
        state_d = WAIT_DONE;
`ifdef FETCH_PAGE_CROSS_EN
        page_cross_d = cross_q;
`endif
      end
      WAIT_DONE: begin
        if (pc_load) pc_d = pc_load_val;
        if (instruction_done) begin
          ready_d = 1'b0;
          state_d = IDLE;
`ifdef FETCH_PAGE_CROSS_EN
          page_cross_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      instr_q   <= '0;
      operand_q <= '0;
      eff_q     <= '0;
      lo_q      <= '0;
      ptr_q     <= '0;
      ready_q   <= 1'b0;
`ifdef FETCH_PAGE_CROSS_EN
      cross_q      <= 1'b0;
      page_cross_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      instr_q   <= instr_d;
      operand_q <= operand_d;
      eff_q     <= eff_d;
      lo_q      <= lo_d;
      ptr_q     <= ptr_d;
      ready_q   <= ready_d;
`ifdef FETCH_PAGE_CROSS_EN
      cross_q      <= cross_d;
      page_cross_q <= page_cross_d;
`endif
    end
  end

  assign mem.mem_addr      = addr_q;
  assign mem.mem_rd        = rd_q;
  assign instruction       = instr_q;
  assign operand           = operand_q;
  assign eff_addr          = eff_q;
  assign instruction_ready = ready_q;
  assign pc                = pc_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed plan steps, then random instructions against a byte-level reference model.
`timescale 1ns/1ps
module tb_fetch_sequencer;
  localparam logic [15:0] RESET_PC = 16'h0200;
  localparam int K_IMPL = 0, K_IMM = 1, K_ZP = 2, K_ZPX = 3, K_ABS = 4,
                 K_ABSX = 5, K_ABSY = 6, K_INDX = 7, K_INDY = 8;
`ifdef FETCH_PAGE_CROSS_EN
  localparam bit PEN_EN = 1'b1;
`else
  localparam bit PEN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0, run = 1'b0, pc_load = 1'b0, instruction_done = 1'b0;
  logic [15:0] pc_load_val = '0;
  logic [7:0]  x_in = '0, y_in = '0;
  logic [7:0]  instruction, operand;
  logic [15:0] eff_addr, pc;
  logic        instruction_ready, busy, page_cross;

  fetch_sequencer_if #(.ADDR_WIDTH(16), .REG_WIDTH(8)) bus ();

  fetch_sequencer #(.ADDR_WIDTH(16), .REG_WIDTH(8), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .x_in(x_in), .y_in(y_in), .mem(bus), .instruction(instruction), .operand(operand),
    .eff_addr(eff_addr), .instruction_ready(instruction_ready),
    .instruction_done(instruction_done), .pc(pc), .busy(busy), .page_cross(page_cross)
  );

  always #5 clk = ~clk;

  // Memory responder: each read completes after wait_cycles idle cycles.
  logic [7:0] memory [0:65535];
  int   wait_cycles = 0;
  int   wait_cnt = 0;
  logic inject_valid = 1'b0;
  assign bus.mem_valid = (bus.mem_rd && (wait_cnt >= wait_cycles)) || inject_valid;
  assign bus.mem_rdata = memory[bus.mem_addr];
  always @(posedge clk)
    if (bus.mem_rd && !bus.mem_valid) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_instr, exp_operand;
  logic [15:0] exp_eff, exp_pc;
  bit          exp_cross, exp_indirect;
  int          exp_addrs[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic refModel(input int start, input int x, input int y);
    int op, cc, bbb, kind, p, lo, hi, zp, plo, phi, idx;
    exp_addrs.delete();
    op = int'(memory[16'(start)]);
    exp_addrs.push_back(start);
    p = (start + 1) % 65536;
    cc = op % 4;
    bbb = (op / 4) % 8;
    kind = K_IMPL;
    if (cc == 1) begin
      case (bbb)
        0: kind = K_INDX;  1: kind = K_ZP;   2: kind = K_IMM;  3: kind = K_ABS;
        4: kind = K_INDY;  5: kind = K_ZPX;  6: kind = K_ABSY; default: kind = K_ABSX;
      endcase
    end else if (cc != 3) begin
      case (bbb)
        0: kind = K_IMM; 1: kind = K_ZP; 3: kind = K_ABS; 5: kind = K_ZPX; 7: kind = K_ABSX;
        default: kind = K_IMPL;
      endcase
    end
    exp_instr = 8'(op); exp_operand = '0; exp_eff = '0; exp_cross = 0; exp_indirect = 0;
    lo = 0;
    if (kind != K_IMPL) begin
      lo = int'(memory[16'(p)]);
      exp_addrs.push_back(p);
      p = (p + 1) % 65536;
    end
    if (kind == K_IMM) exp_operand = 8'(lo);
    else if (kind == K_ZP) exp_eff = 16'(lo);
    else if (kind == K_ZPX) exp_eff = 16'((lo + x) % 256);
    else if (kind == K_ABS || kind == K_ABSX || kind == K_ABSY) begin
      hi = int'(memory[16'(p)]);
      exp_addrs.push_back(p);
      p = (p + 1) % 65536;
      idx = (kind == K_ABSX) ? x : (kind == K_ABSY) ? y : 0;
      exp_eff = 16'((hi * 256 + lo + idx) % 65536);
      exp_cross = (lo + idx) > 255;
    end else if (kind == K_INDX || kind == K_INDY) begin
      zp = (kind == K_INDX) ? (lo + x) % 256 : lo;
      exp_addrs.push_back(zp);
      exp_addrs.push_back((zp + 1) % 256);
      plo = int'(memory[16'(zp)]);
      phi = int'(memory[16'((zp + 1) % 256)]);
      idx = (kind == K_INDY) ? y : 0;
      exp_eff = 16'((phi * 256 + plo + idx) % 65536);
      exp_cross = (plo + idx) > 255;
      exp_indirect = 1;
    end
    exp_pc = 16'(p);
  endtask

  task automatic applyStimulus(input string tag, input bit use_load, input logic [15:0] start,
                               input logic [7:0] x, input logic [7:0] y, input int wait_n,
                               input bit done_early, input bit load_on_done, input logic [15:0] load_val);
    int cycles, holds_bad, lat_exp;
    bit seen, prev_wait, pen;
    logic [15:0] last_addr;
    logic [31:0] got;
    int got_addrs[$];
    x_in = x; y_in = y; wait_cycles = wait_n;
    if (use_load) begin
      pc_load = 1'b1; pc_load_val = start;
      @(posedge clk); @(negedge clk);
      pc_load = 1'b0;
      checkOutput({tag, "/pc_load"}, pc, start);
    end
    refModel(int'(start), int'(x), int'(y));
    pen = PEN_EN && exp_cross;
    run = 1'b1;
    cycles = 0; holds_bad = 0; seen = 0; prev_wait = 0; last_addr = '0;
    while (!seen && cycles < 200) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      run = 1'b0;
      instruction_done = done_early && (cycles == 1);
      if (bus.mem_rd && bus.mem_valid) got_addrs.push_back(int'(bus.mem_addr));
      if (prev_wait && !(bus.mem_rd === 1'b1 && bus.mem_addr === last_addr)) holds_bad++;
      prev_wait = bus.mem_rd && !bus.mem_valid;
      last_addr = bus.mem_addr;
      seen = instruction_ready;
    end
    instruction_done = 1'b0;
    lat_exp = 2 + exp_addrs.size() * (1 + wait_n) + int'(exp_indirect) + int'(pen);
    checkOutput({tag, "/ready_seen"}, seen, 1);
    checkOutput({tag, "/latency"}, cycles, lat_exp);
    checkOutput({tag, "/instruction"}, instruction, exp_instr);
    checkOutput({tag, "/operand"}, operand, exp_operand);
    checkOutput({tag, "/eff_addr"}, eff_addr, exp_eff);
    checkOutput({tag, "/pc"}, pc, exp_pc);
    checkOutput({tag, "/page_cross"}, page_cross, pen);
    checkOutput({tag, "/busy"}, busy, 1);
    checkOutput({tag, "/rd_hold"}, holds_bad, 0);
    checkOutput({tag, "/read_count"}, got_addrs.size(), exp_addrs.size());
    for (int i = 0; i < exp_addrs.size(); i++) begin
      got = (i < got_addrs.size()) ? 32'(got_addrs[i]) : 32'hFFFF_FFFF;
      checkOutput($sformatf("%s/read_addr%0d", tag, i), got, exp_addrs[i]);
    end
    repeat (2) begin @(posedge clk); @(negedge clk); end
    checkOutput({tag, "/ready_held"}, instruction_ready, 1);
    checkOutput({tag, "/eff_held"}, eff_addr, exp_eff);
    instruction_done = 1'b1;
    if (load_on_done) begin pc_load = 1'b1; pc_load_val = load_val; end
    @(posedge clk); @(negedge clk);
    instruction_done = 1'b0; pc_load = 1'b0;
    checkOutput({tag, "/ready_cleared"}, instruction_ready, 0);
    checkOutput({tag, "/idle"}, busy, 0);
    checkOutput({tag, "/page_cross_cleared"}, page_cross, 0);
    checkOutput({tag, "/pc_after_done"}, pc, load_on_done ? load_val : exp_pc);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) memory[i] = 8'($urandom);
    memory[16'h0200] = 8'hA9; memory[16'h0201] = 8'h42;
    memory[16'h0300] = 8'hB5; memory[16'h0301] = 8'hF0;
    memory[16'h0400] = 8'h7D; memory[16'h0401] = 8'hF0; memory[16'h0402] = 8'h12;
    memory[16'h0500] = 8'hB1; memory[16'h0501] = 8'hFF;
    memory[16'h00FF] = 8'h34; memory[16'h0000] = 8'h12;
    memory[16'h0700] = 8'hEA;
    memory[16'h0800] = 8'hA1; memory[16'h0801] = 8'h80;
    memory[16'h0085] = 8'hCD; memory[16'h0086] = 8'hAB;
    memory[16'h0900] = 8'hB9; memory[16'h0901] = 8'h10; memory[16'h0902] = 8'h20;
    memory[16'h0600] = 8'h6D; memory[16'h0601] = 8'h34; memory[16'h0602] = 8'h12;

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset/pc", pc, RESET_PC);
    checkOutput("reset/ready", instruction_ready, 0);
    checkOutput("reset/busy", busy, 0);
    checkOutput("reset/mem_rd", bus.mem_rd, 0);
    checkOutput("reset/mem_addr", bus.mem_addr, 0);
    checkOutput("reset/eff_addr", eff_addr, 0);
    reset_n = 1'b1;

    applyStimulus("lda_imm",   0, 16'h0200, 8'h00, 8'h00, 0, 0, 0, 16'h0000);
    applyStimulus("zp_x",      1, 16'h0300, 8'h20, 8'h00, 0, 0, 0, 16'h0000);
    applyStimulus("abs_x",     1, 16'h0400, 8'h20, 8'h00, 0, 0, 0, 16'h0000);
    applyStimulus("ind_y",     1, 16'h0500, 8'h00, 8'h05, 0, 0, 0, 16'h0000);
    applyStimulus("implied",   1, 16'h0700, 8'h00, 8'h00, 0, 1, 0, 16'h0000);
    applyStimulus("ind_x",     1, 16'h0800, 8'h05, 8'h00, 0, 0, 1, 16'h1234);
    applyStimulus("abs_y_wait", 1, 16'h0900, 8'h00, 8'h03, 3, 0, 0, 16'h0000);

    $display("[TB] reset mid-fetch");
    x_in = 8'h00; wait_cycles = 3;
    pc_load = 1'b1; pc_load_val = 16'h0600;
    @(posedge clk); @(negedge clk);
    pc_load = 1'b0; run = 1'b1;
    repeat (9) begin @(posedge clk); @(negedge clk); run = 1'b0; end
    checkOutput("midrst/hi_addr", bus.mem_addr, 16'h0602);
    checkOutput("midrst/hi_rd", bus.mem_rd, 1);
    reset_n = 1'b0;
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    checkOutput("midrst/pc", pc, RESET_PC);
    checkOutput("midrst/ready", instruction_ready, 0);
    checkOutput("midrst/busy", busy, 0);
    checkOutput("midrst/mem_rd", bus.mem_rd, 0);
    inject_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    inject_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("late_valid/busy", busy, 0);
    checkOutput("late_valid/pc", pc, RESET_PC);
    checkOutput("late_valid/instruction", instruction, 0);

    $display("[TB] random instructions");
    for (int n = 0; n < 24; n++) begin
      logic [15:0] rpc;
      rpc = 16'($urandom);
      memory[rpc] = 8'($urandom);
      memory[16'(rpc + 16'd1)] = 8'($urandom);
      memory[16'(rpc + 16'd2)] = 8'($urandom);
      applyStimulus($sformatf("rand%0d", n), 1, rpc, 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
